commit_queue: RTL and testbench
===============================

COMMIT_QUEUE -- requirements
Module: commit_queue

Interface
- REQ-001 The block SHALL have parameter NR_COMMIT_PORTS, default 2, giving the number of in-order retire ports presented to the commit stage.
- REQ-002 The block SHALL have parameter NR_ENTRIES, default 8, giving the queue depth; it is a power of two and ≤ 2**TRANS_ID_BITS.
- REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
- REQ-004 rst_i  in  1  asynchronous, active-high reset.
- REQ-005 flush_i  in  1  discards all entries.
- REQ-006 issue_valid_i  in  1  new in-order entry offered.
- REQ-007 issue_instr_i  in  scoreboard_entry_t  entry payload (pc, fu, op, rd, ex).
- REQ-008 issue_ready_o  out  1  queue can accept an entry.
- REQ-009 issue_trans_id_o  out  TRANS_ID_BITS  slot index assigned to the entry accepted this cycle.
- REQ-010 wb_valid_i  in  1  functional-unit writeback.
- REQ-011 wb_trans_id_i  in  TRANS_ID_BITS  target slot of the writeback.
- REQ-012 wb_result_i  in  XLEN  result data.
- REQ-013 wb_ex_i  in  exception_t  exception from the functional unit.
- REQ-014 commit_instr_o  out  [NR_COMMIT_PORTS] scoreboard_entry_t  head entries, oldest on port 0.
- REQ-015 commit_ack_i  in  NR_COMMIT_PORTS  retire acknowledge from the commit stage.
- REQ-016 empty_o  out  1  no allocated entries.

Function
- REQ-017 The block SHALL be a circular buffer with read pointer, write pointer and an occupancy count of width $clog2(NR_ENTRIES)+1; pointers wrap modulo NR_ENTRIES.
- REQ-018 The block SHALL drive issue_ready_o = (count < NR_ENTRIES), computed from registered count only; a same-cycle retire SHALL NOT free space for a same-cycle issue.
- REQ-019 On issue_valid_i && issue_ready_o the block SHALL store the payload at the write pointer with done=0, set trans_id to the slot index, and advance the write pointer by one.
- REQ-020 issue_trans_id_o SHALL equal the current write pointer, combinationally.
- REQ-021 On wb_valid_i to an allocated slot, the block SHALL write result, set done=1, and overwrite ex only when wb_ex_i.valid; writebacks to unallocated slots SHALL be ignored.
- REQ-022 commit_instr_o[i] SHALL show the slot at read pointer + i; its valid SHALL be 1 only if that slot is allocated and done, and every port j<i is also valid.
- REQ-023 The block SHALL honour commit_ack_i[i] only if commit_ack_i[0..i-1] are all set and commit_instr_o[i].valid; the read pointer SHALL advance by the number of honoured acks and count SHALL update by issued minus retired.
- REQ-024 Issue and retire in the same cycle SHALL both take effect; count SHALL never underflow or overflow.
- REQ-025 flush_i SHALL reset pointers and count to 0 and clear all done bits in one cycle, with priority over issue, writeback and ack in that cycle.

Reset
- REQ-026 While rst_i is asserted: pointers=0, count=0, all done bits=0, issue_ready_o=1, empty_o=1, all commit_instr_o[i].valid=0; assertion mid-operation SHALL abandon all entries immediately.

Configuration
- REQ-027 With COMMIT_QUEUE_WB_BYPASS_EN defined, a writeback to a head slot SHALL be forwarded combinationally, so that commit_instr_o shows it valid with wb_result_i in the same cycle.
- REQ-028 Without COMMIT_QUEUE_WB_BYPASS_EN, the head slot SHALL become valid in the cycle after the writeback.

Structure
- REQ-029 scoreboard_entry_t, exception_t, TRANS_ID_BITS and XLEN SHALL come from ariane_pkg; no new package types SHALL be added.
- REQ-030 The block SHALL be a single module with no sub-module.

Verification
- REQ-031 Reset, then issue 3 entries, then write back ids 2,1,0 in order with results 0x30,0x20,0x10 -> commit ports show ids 0/1 valid only after id 0 completes, with results 0x10/0x20.
- REQ-032 Fill 8 entries -> issue_ready_o=0; in the next cycle ack port 0 while issuing -> issue refused that cycle, accepted in the following cycle with trans_id 0 (wrap).
- REQ-033 Heads done, commit_ack_i=2'b10 -> nothing retires and count stays unchanged.
- REQ-034 Writeback to an unallocated id 5 while count=2 -> no state change.
- REQ-035 flush_i asserted together with an issue and an ack at count=4 -> next cycle count=0, empty_o=1, issue_trans_id_o=0.
- REQ-036 Bypass: with COMMIT_QUEUE_WB_BYPASS_EN, writeback to the head with result 0xAB -> port 0 is valid in the same cycle with 0xAB; without the macro -> port 0 is valid one cycle later.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared core types used by the commit queue: widths, exception and
// scoreboard entry payloads.
package ariane_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef enum logic [2:0] {
        NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR
    } fu_t;

    typedef enum logic [3:0] {
        ADD, SUB, ANDL, ORL, XORL, SLL, SRL, SRA,
        LD, SD, MUL, DIV, JALR, BEQ, CSRRW, NOP
    } fu_op;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic [XLEN-1:0]          pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        fu_op                     op;
        logic [4:0]               rd;
        logic [XLEN-1:0]          result;
        logic                     valid;
        exception_t               ex;
    } scoreboard_entry_t;

endpackage

// File: rtl/commit_queue.sv
// In-order commit queue: circular buffer of scoreboard entries that
// collects out-of-order writebacks and presents retire-ready heads.
// Optional same-cycle writeback forwarding: COMMIT_QUEUE_WB_BYPASS_EN.
module commit_queue
    import ariane_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned NR_ENTRIES      = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    input  scoreboard_entry_t        issue_instr_i,
    output logic                     issue_ready_o,
    output logic [TRANS_ID_BITS-1:0] issue_trans_id_o,
    input  logic                     wb_valid_i,
    input  logic [TRANS_ID_BITS-1:0] wb_trans_id_i,
    input  logic [XLEN-1:0]          wb_result_i,
    input  exception_t               wb_ex_i,
    output scoreboard_entry_t        commit_instr_o [NR_COMMIT_PORTS],
    input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
    localparam int unsigned CNT_W = $clog2(NR_ENTRIES) + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    scoreboard_entry_t       mem_q [NR_ENTRIES];
    scoreboard_entry_t       mem_d [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]   done_q, done_d;
    ptr_t                    rd_ptr_q, rd_ptr_d;
    ptr_t                    wr_ptr_q, wr_ptr_d;
    cnt_t                    count_q, count_d;

    logic                    issue_fire;
    logic                    wb_in_range;
    ptr_t                    wb_slot;
    cnt_t                    retire_cnt;

    // A slot is live when its distance from the head is below the count.
    function automatic logic is_alloc(ptr_t slot, ptr_t rd, cnt_t cnt);
        ptr_t off;
        off = slot - rd;
        return cnt_t'(off) < cnt;
    endfunction

    assign issue_ready_o    = count_q < cnt_t'(NR_ENTRIES);
    assign issue_trans_id_o = TRANS_ID_BITS'(wr_ptr_q);
    assign empty_o          = count_q == '0;
    assign issue_fire       = issue_valid_i && issue_ready_o;
    assign wb_in_range      = 32'(wb_trans_id_i) < NR_ENTRIES;
    assign wb_slot          = ptr_t'(wb_trans_id_i);

    // Head ports: valid only for a contiguous run of done entries.
    always_comb begin : commit_view
        logic              chain;
        logic              done;
        ptr_t              idx;
        scoreboard_entry_t e;
        chain = 1'b1;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            idx  = rd_ptr_q + ptr_t'(i);
            e    = mem_q[idx];
            done = done_q[idx];
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
            if (wb_valid_i && wb_in_range && wb_slot == idx) begin
                e.result = wb_result_i;
                if (wb_ex_i.valid) e.ex = wb_ex_i;
                done = 1'b1;
            end
`endif
            e.valid = chain && done && (cnt_t'(i) < count_q);
            chain   = e.valid;
            commit_instr_o[i] = e;
        end
    end

    // Count the in-order prefix of acknowledged, valid head ports.
    always_comb begin : retire_count
        logic chain;
        chain      = 1'b1;
        retire_cnt = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (chain && commit_ack_i[i] && commit_instr_o[i].valid)
                retire_cnt = retire_cnt + cnt_t'(1);
            else
                chain = 1'b0;
        end
    end

    // Next-state: writeback, retire, issue, with flush overriding all.
    always_comb begin : next_state
        mem_d    = mem_q;
        done_d   = done_q;
        rd_ptr_d = rd_ptr_q + ptr_t'(retire_cnt);
        wr_ptr_d = wr_ptr_q + ptr_t'(issue_fire);
        count_d  = count_q + cnt_t'(issue_fire) - retire_cnt;

        if (wb_valid_i && wb_in_range &&
            is_alloc(wb_slot, rd_ptr_q, count_q)) begin
            mem_d[wb_slot].result = wb_result_i;
            done_d[wb_slot]       = 1'b1;
            if (wb_ex_i.valid) mem_d[wb_slot].ex = wb_ex_i;
        end

        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (cnt_t'(i) < retire_cnt)
                done_d[rd_ptr_q + ptr_t'(i)] = 1'b0;
        end

        if (issue_fire) begin
            mem_d[wr_ptr_q]          = issue_instr_i;
            mem_d[wr_ptr_q].trans_id = TRANS_ID_BITS'(wr_ptr_q);
            mem_d[wr_ptr_q].valid    = 1'b0;
            done_d[wr_ptr_q]         = 1'b0;
        end

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            done_d   = '0;
        end
    end

    // Control state: pointers, count and done bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    // Payload storage; liveness is tracked by count, so no reset needed.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_commit_queue.sv
// Directed bench for commit_queue: ordering, full/wrap, partial acks,
// stray writebacks, flush priority and writeback forwarding.
module tb_commit_queue;
    import ariane_pkg::*;

`ifdef COMMIT_QUEUE_WB_BYPASS_EN
    localparam logic [63:0] BYP = 64'd1;
`else
    localparam logic [63:0] BYP = 64'd0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic                     issue_valid;
    scoreboard_entry_t        issue_instr;
    logic                     issue_ready;
    logic [TRANS_ID_BITS-1:0] issue_trans_id;
    logic                     wb_valid;
    logic [TRANS_ID_BITS-1:0] wb_trans_id;
    logic [XLEN-1:0]          wb_result;
    exception_t               wb_ex;
    scoreboard_entry_t        commit_instr [2];
    logic [1:0]               commit_ack;
    logic                     empty;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    commit_queue dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .issue_valid_i   (issue_valid),
        .issue_instr_i   (issue_instr),
        .issue_ready_o   (issue_ready),
        .issue_trans_id_o(issue_trans_id),
        .wb_valid_i      (wb_valid),
        .wb_trans_id_i   (wb_trans_id),
        .wb_result_i     (wb_result),
        .wb_ex_i         (wb_ex),
        .commit_instr_o  (commit_instr),
        .commit_ack_i    (commit_ack),
        .empty_o         (empty)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic wb(input int id, input logic [63:0] res);
        wb_valid    = 1'b1;
        wb_trans_id = TRANS_ID_BITS'(id);
        wb_result   = res;
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_instr = '0;
        wb_valid    = 1'b0;
        wb_trans_id = '0;
        wb_result   = '0;
        wb_ex       = '0;
        commit_ack  = '0;

        // reset state
        mid;
        chk("rst_ready", 64'(issue_ready), 1);
        chk("rst_empty", 64'(empty), 1);
        chk("rst_p0v", 64'(commit_instr[0].valid), 0);
        chk("rst_p1v", 64'(commit_instr[1].valid), 0);
        chk("rst_tid", 64'(issue_trans_id), 0);
        step;
        rst = 1'b0;

        // issue 3, write back 2,1,0
        for (int k = 0; k < 3; k++) begin
            issue_valid    = 1'b1;
            issue_instr.pc = 64'h100 + 64'(4 * k);
            issue_instr.rd = 5'(k + 1);
            mid;
            chk("iss_tid", 64'(issue_trans_id), 64'(k));
            step;
        end
        issue_valid = 1'b0;
        wb(2, 64'h30);
        mid;
        chk("t1_cnt", 64'(dut.count_q), 3);
        chk("t1_p0v_a", 64'(commit_instr[0].valid), 0);
        step;
        wb(1, 64'h20);
        mid;
        chk("t1_p0v_b", 64'(commit_instr[0].valid), 0);
        step;
        wb(0, 64'h10);
        mid;
        chk("t1_byp_p0v", 64'(commit_instr[0].valid), BYP);
        chk("t1_byp_p1v", 64'(commit_instr[1].valid), BYP);
        step;
        wb_valid = 1'b0;
        commit_ack = 2'b10;
        mid;
        chk("t1_p0v", 64'(commit_instr[0].valid), 1);
        chk("t1_p0res", commit_instr[0].result, 64'h10);
        chk("t1_p0tid", 64'(commit_instr[0].trans_id), 0);
        chk("t1_p0pc", commit_instr[0].pc, 64'h100);
        chk("t1_p1v", 64'(commit_instr[1].valid), 1);
        chk("t1_p1res", commit_instr[1].result, 64'h20);
        chk("t1_p1tid", 64'(commit_instr[1].trans_id), 1);
        step;
        // ack 2'b10 must retire nothing
        commit_ack = 2'b11;
        mid;
        chk("ack10_cnt", 64'(dut.count_q), 3);
        chk("ack10_p0tid", 64'(commit_instr[0].trans_id), 0);
        step;
        commit_ack = 2'b01;
        mid;
        chk("ack11_cnt", 64'(dut.count_q), 1);
        chk("ack11_p0tid", 64'(commit_instr[0].trans_id), 2);
        chk("ack11_p0res", commit_instr[0].result, 64'h30);
        chk("ack11_p1v", 64'(commit_instr[1].valid), 0);
        step;
        commit_ack = 2'b00;
        mid;
        chk("t1_empty", 64'(empty), 1);

        // stray writeback to unallocated id 5 at count 2
        step;
        for (int k = 0; k < 2; k++) begin
            issue_valid    = 1'b1;
            issue_instr.pc = 64'h200 + 64'(4 * k);
            step;
        end
        issue_valid = 1'b0;
        wb(5, 64'hDEAD);
        wb_ex.valid = 1'b1;
        wb_ex.cause = 64'd7;
        step;
        wb_valid = 1'b0;
        mid;
        chk("stray_cnt", 64'(dut.count_q), 2);
        chk("stray_done5", 64'(dut.done_q[5]), 0);
        chk("stray_p0v", 64'(commit_instr[0].valid), 0);
        chk("stray_tid", 64'(issue_trans_id), 5);
        step;
        wb(3, 64'h33);
        wb_ex.cause = 64'd2;
        step;
        wb(4, 64'h44);
        wb_ex = '0;
        step;
        wb_valid = 1'b0;
        commit_ack = 2'b11;
        mid;
        chk("ex_p0v", 64'(commit_instr[0].valid), 1);
        chk("ex_p0exv", 64'(commit_instr[0].ex.valid), 1);
        chk("ex_p0cause", commit_instr[0].ex.cause, 2);
        chk("ex_p1exv", 64'(commit_instr[1].ex.valid), 0);
        chk("ex_p1res", commit_instr[1].result, 64'h44);
        step;
        commit_ack = 2'b00;

        // flush beats issue and ack at count 4
        for (int k = 0; k < 4; k++) begin
            issue_valid = 1'b1;
            step;
        end
        issue_valid = 1'b0;
        wb(5, 64'h55);
        step;
        wb_valid    = 1'b0;
        flush       = 1'b1;
        issue_valid = 1'b1;
        commit_ack  = 2'b01;
        mid;
        chk("fl_cnt_pre", 64'(dut.count_q), 4);
        chk("fl_p0v_pre", 64'(commit_instr[0].valid), 1);
        step;
        flush       = 1'b0;
        issue_valid = 1'b0;
        commit_ack  = 2'b00;
        mid;
        chk("fl_cnt", 64'(dut.count_q), 0);
        chk("fl_empty", 64'(empty), 1);
        chk("fl_tid", 64'(issue_trans_id), 0);
        chk("fl_p0v", 64'(commit_instr[0].valid), 0);
        step;

        // fill, then retire+issue in same cycle: issue refused
        for (int k = 0; k < 8; k++) begin
            issue_valid = 1'b1;
            mid;
            chk("fill_tid", 64'(issue_trans_id), 64'(k));
            step;
        end
        issue_valid = 1'b0;
        wb(0, 64'h77);
        mid;
        chk("full_ready", 64'(issue_ready), 0);
        chk("full_cnt", 64'(dut.count_q), 8);
        chk("full_tid", 64'(issue_trans_id), 0);
        step;
        wb_valid    = 1'b0;
        commit_ack  = 2'b01;
        issue_valid = 1'b1;
        mid;
        chk("full_ack_ready", 64'(issue_ready), 0);
        step;
        commit_ack = 2'b00;
        mid;
        chk("wrap_ready", 64'(issue_ready), 1);
        chk("wrap_cnt", 64'(dut.count_q), 7);
        chk("wrap_tid", 64'(issue_trans_id), 0);
        step;
        issue_valid = 1'b0;
        mid;
        chk("wrap_cnt2", 64'(dut.count_q), 8);
        chk("wrap_ready2", 64'(issue_ready), 0);
        chk("wrap_tid2", 64'(issue_trans_id), 1);
        step;

        // writeback forwarding at the head
        flush = 1'b1;
        step;
        flush       = 1'b0;
        issue_valid = 1'b1;
        step;
        issue_valid = 1'b0;
        wb(0, 64'hAB);
        mid;
        chk("byp_p0v", 64'(commit_instr[0].valid), BYP);
        step;
        wb_valid = 1'b0;
        mid;
        chk("byp_p0v_late", 64'(commit_instr[0].valid), 1);
        chk("byp_p0res", commit_instr[0].result, 64'hAB);
        step;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
